multibyte_add_ctrl: RTL and testbench
=====================================

// Module: multibyte_add_ctrl
// PURPOSE
//  Sequencer that time-shares one 8-bit ripple-carry byte adder to add NBYTES-wide operands.
//  Operands are accepted over a valid/ready start handshake and added one byte per cycle,
//  LSB first, with the carry held in a register between bytes.
//  The full sum and carry-out are presented over a valid/ready done handshake.
//  Sits between operand producers and the consumer of wide sums in the arithmetic path.
// PARAMETERS
//  NBYTES  4  operand width in bytes (>=1); data width = 8*NBYTES
// PORTS
//  Clk         in   1           single clock; all state changes on rising edge
//  Rst         in   1           synchronous, active-high reset
//  StartValid  in   1           operands valid
//  StartReady  out  1           block can accept operands
//  Ain         in   8*NBYTES    operand A, sampled only on start accept
//  Bin         in   8*NBYTES    operand B, sampled only on start accept
//  Ci          in   1           carry-in, sampled only on start accept
//  Sout        out  8*NBYTES    sum (meaningful when DoneValid=1)
//  Co          out  1           final carry-out (meaningful when DoneValid=1)
//  DoneValid   out  1           result valid
//  DoneReady   in   1           consumer takes result
//  Busy        out  1           high in RUN or DONE
// BEHAVIOUR
//  - Reset: state=IDLE, StartReady=1, DoneValid=0, Busy=0, Sout=0, Co=0, idx=0, carry=0.
//    Rst mid-operation aborts in the same edge; result is discarded.
//  - FSM states: IDLE, RUN, DONE.
//    - IDLE: StartReady=1. On StartValid=1, latch Ain/Bin, load carry<=Ci, idx<=0, go to RUN.
//    - RUN: each cycle, byte adder computes A[idx]+B[idx]+carry. On the edge, Sout byte idx<=S,
//      carry<=Co, idx<=idx+1. When idx==NBYTES-1: Co<=byte Co and go to DONE.
//    - DONE: DoneValid=1. Sout and Co are held stable until DoneReady=1, then go to IDLE.
//  - Latency: DoneValid rises exactly NBYTES cycles after the accept edge.
//    Back-to-back throughput is one operation per NBYTES+2 cycles.
//  - StartReady=0 in RUN and DONE. StartValid is ignored there, even in the same cycle
//    as the DoneReady handshake; there is no DONE->RUN shortcut.
//  - Arithmetic is modulo 2^(8*NBYTES); overflow appears only as Co.
//  - NBYTES=1: one RUN cycle. idx is $clog2(NBYTES) bits wide (minimum 1) and never wraps
//    past NBYTES-1.
// CONFIGURATION
//  SUB_EN defined:
//    - Adds input port Sub (1 bit), sampled on accept.
//    - Sub=1: B bytes are bit-inverted into the adder, carry-in is forced to 1 (Ci ignored),
//      so Sout=A-B and Co=1 means no borrow.
//    - Sub=0: behaviour is identical to the add-only build.
//  SUB_EN undefined: no Sub port; addition only.
// STRUCTURE
//  - Shared package adder_ctrl_pkg: BYTE_W=8, state enum {IDLE,RUN,DONE}.
//  - One sub-module byte_adder8: combinational 8-bit ripple-carry adder (A,B,Ci -> S,Co).
//    Instantiated once; no other arithmetic in this block.
// TESTING (NBYTES=4 unless noted)
//  1. A=0x000000FF, B=0x00000001, Ci=0 -> Sout=0x00000100, Co=0; DoneValid 4 cycles after accept.
//  2. A=0xFFFFFFFF, B=0x00000000, Ci=1 -> Sout=0x00000000, Co=1 (carry ripples across all bytes).
//  3. Hold DoneReady=0 for 5 cycles in DONE while pulsing StartValid -> Sout/Co/DoneValid stable,
//     StartReady=0, no accept.
//  4. Rst=1 two cycles into RUN -> next cycle IDLE, StartReady=1, DoneValid=0, Sout=0, Co=0.
//  5. SUB_EN, Sub=1: A=5, B=7 -> Sout=0xFFFFFFFE, Co=0; A=7, B=5 -> Sout=0x00000002, Co=1.
//  6. StartValid and DoneReady held 1, NBYTES=1 and 4 -> accepts every NBYTES+2 cycles,
//     results match a reference model.

Source files
------------

// File: rtl/adder_ctrl_pkg.sv
// Shared types for the multibyte adder sequencer: byte width and FSM state encoding.
package adder_ctrl_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/byte_adder8.sv
// Combinational 8-bit ripple-carry adder; the only arithmetic element of the sequencer.
module byte_adder8
    import adder_ctrl_pkg::*;
(
    input  logic [BYTE_W-1:0] A,
    input  logic [BYTE_W-1:0] B,
    input  logic              Ci,
    output logic [BYTE_W-1:0] S,
    output logic              Co
);

    logic [BYTE_W:0] c;

    always_comb begin
        c    = '0;
        S    = '0;
        c[0] = Ci;
        for (int unsigned i = 0; i < BYTE_W; i++) begin
            S[i]   = A[i] ^ B[i] ^ c[i];
            c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
        end
        Co = c[BYTE_W];
    end

endmodule

// File: rtl/multibyte_add_ctrl.sv
// Adds NBYTES-wide operands one byte per cycle (LSB first) through a single byte adder.
// Define SUB_EN to add the Sub port (A-B via inverted B and forced carry-in).
module multibyte_add_ctrl
    import adder_ctrl_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     StartValid,
    output logic                     StartReady,
    input  logic [BYTE_W*NBYTES-1:0] Ain,
    input  logic [BYTE_W*NBYTES-1:0] Bin,
    input  logic                     Ci,
`ifdef SUB_EN
    input  logic                     Sub,
`endif
    output logic [BYTE_W*NBYTES-1:0] Sout,
    output logic                     Co,
    output logic                     DoneValid,
    input  logic                     DoneReady,
    output logic                     Busy
);

    localparam int W    = BYTE_W * NBYTES;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NBYTES - 1);

    state_t state, state_nxt;

    logic [W-1:0]      a_q, b_q, sum_q;
    logic              co_q, carry_q;
    logic [IDXW-1:0]   idx_q;
    logic [BYTE_W-1:0] a_byte, b_byte, s_byte;
    logic              co_byte;
    logic              accept, last;
`ifdef SUB_EN
    logic              sub_q;
`endif

    assign accept = (state == IDLE) && StartValid;
    assign last   = (idx_q == LAST);
    assign a_byte = a_q[int'(idx_q)*BYTE_W +: BYTE_W];
`ifdef SUB_EN
    assign b_byte = sub_q ? ~b_q[int'(idx_q)*BYTE_W +: BYTE_W] : b_q[int'(idx_q)*BYTE_W +: BYTE_W];
`else
    assign b_byte = b_q[int'(idx_q)*BYTE_W +: BYTE_W];
`endif

    byte_adder8 u_add (
        .A  (a_byte),
        .B  (b_byte),
        .Ci (carry_q),
        .S  (s_byte),
        .Co (co_byte)
    );

    always_ff @(posedge Clk) begin
        if (Rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // StartValid is deliberately ignored outside IDLE, so DONE always returns through IDLE.
    always_comb begin
        state_nxt  = state;
        StartReady = 1'b0;
        DoneValid  = 1'b0;
        Busy       = 1'b0;
        unique case (state)
            IDLE: begin
                StartReady = 1'b1;
                if (StartValid) state_nxt = RUN;
            end
            RUN: begin
                Busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                Busy      = 1'b1;
                DoneValid = 1'b1;
                if (DoneReady) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
`ifdef SUB_EN
            sub_q   <= 1'b0;
`endif
        end else if (accept) begin
            a_q   <= Ain;
            b_q   <= Bin;
            idx_q <= '0;
`ifdef SUB_EN
            sub_q   <= Sub;
            carry_q <= Sub | Ci;
`else
            carry_q <= Ci;
`endif
        end else if (state == RUN) begin
            sum_q[int'(idx_q)*BYTE_W +: BYTE_W] <= s_byte;
            carry_q <= co_byte;
            if (last) co_q  <= co_byte;
            else      idx_q <= idx_q + 1'b1;
        end
    end

    assign Sout = sum_q;
    assign Co   = co_q;

endmodule

// File: tb/tb_multibyte_add_ctrl.sv
// Self-checking bench for multibyte_add_ctrl: vector table, corner sequences and streaming at NBYTES=4 and 1.
`timescale 1ns/1ps
module tb_multibyte_add_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst4, sv4, sr4, ci4, co4, dv4, dr4, busy4;
    logic [31:0] a4, b4, s4;
    logic        rst1, sv1, sr1, ci1, co1, dv1, dr1, busy1;
    logic [7:0]  a1, b1, s1;
`ifdef SUB_EN
    logic        sub4, sub1;
`endif

    multibyte_add_ctrl #(.NBYTES(4)) dut4 (
        .Clk(clk), .Rst(rst4), .StartValid(sv4), .StartReady(sr4),
        .Ain(a4), .Bin(b4), .Ci(ci4),
`ifdef SUB_EN
        .Sub(sub4),
`endif
        .Sout(s4), .Co(co4), .DoneValid(dv4), .DoneReady(dr4), .Busy(busy4)
    );

    multibyte_add_ctrl #(.NBYTES(1)) dut1 (
        .Clk(clk), .Rst(rst1), .StartValid(sv1), .StartReady(sr1),
        .Ain(a1), .Bin(b1), .Ci(ci1),
`ifdef SUB_EN
        .Sub(sub1),
`endif
        .Sout(s1), .Co(co1), .DoneValid(dv1), .DoneReady(dr1), .Busy(busy1)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [32:0] exp4[$];
    logic [8:0]  exp1[$];
    logic [32:0] e4;
    logic [8:0]  e1;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic        sub;
        logic [31:0] s;
        logic        co;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [32:0] model4(input logic [31:0] a, input logic [31:0] b,
                                           input logic ci, input logic sub);
        logic [31:0] bb;
        bb = sub ? ~b : b;
        return {1'b0, a} + {1'b0, bb} + 33'(sub ? 1'b1 : ci);
    endfunction

    function automatic logic [8:0] model1(input logic [7:0] a, input logic [7:0] b,
                                          input logic ci, input logic sub);
        logic [7:0] bb;
        bb = sub ? ~b : b;
        return {1'b0, a} + {1'b0, bb} + 9'(sub ? 1'b1 : ci);
    endfunction

    // Scoreboard: a result is consumed on the cycle the done handshake completes.
    always @(negedge clk) begin
        if (!rst4 && dv4 && dr4) begin
            if (exp4.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL dut4 unexpected result: got 0x%0h with no pending expectation", s4);
            end else begin
                e4 = exp4.pop_front();
                check("dut4 sum", 64'(s4), 64'(e4[31:0]));
                check("dut4 co", 64'(co4), 64'(e4[32]));
            end
        end
        if (!rst1 && dv1 && dr1) begin
            if (exp1.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL dut1 unexpected result: got 0x%0h with no pending expectation", s1);
            end else begin
                e1 = exp1.pop_front();
                check("dut1 sum", 64'(s1), 64'(e1[7:0]));
                check("dut1 co", 64'(co1), 64'(e1[8]));
            end
        end
    end

    task automatic start4(input vec_t v);
        check("dut4 start ready", 64'(sr4), 64'(1));
        a4 = v.a; b4 = v.b; ci4 = v.ci;
`ifdef SUB_EN
        sub4 = v.sub;
`endif
        sv4 = 1'b1;
        exp4.push_back({v.co, v.s});
        @(posedge clk); #1;
        sv4 = 1'b0;
        a4  = '1; b4 = '1; ci4 = ~v.ci;
    endtask

    task automatic wait_done4();
        int lat;
        lat = 0;
        while (!dv4 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("dut4 latency", 64'(lat), 64'(4));
    endtask

    task automatic op4(input vec_t v);
        start4(v);
        wait_done4();
        dr4 = 1'b1;
        @(posedge clk); #1;
        dr4 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   last_acc, nacc;
        logic rs;

        rst4 = 1'b1; rst1 = 1'b1; sv4 = 1'b0; sv1 = 1'b0; dr4 = 1'b0; dr1 = 1'b0;
        a4 = '0; b4 = '0; ci4 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0;
`ifdef SUB_EN
        sub4 = 1'b0; sub1 = 1'b0;
`endif

        vecs.push_back('{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0});
        vecs.push_back('{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1});
        vecs.push_back('{32'h12345678, 32'h87654321, 1'b0, 1'b0, 32'h99999999, 1'b0});
        vecs.push_back('{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1});
        vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1});
        vecs.push_back('{32'h00FF00FF, 32'h00010001, 1'b1, 1'b0, 32'h01000101, 1'b0});
`ifdef SUB_EN
        vecs.push_back('{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0});
        vecs.push_back('{32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1});
        vecs.push_back('{32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1});
`endif

        repeat (3) @(posedge clk);
        #1;
        rst4 = 1'b0; rst1 = 1'b0;

        check("dut4 reset startready", 64'(sr4), 64'(1));
        check("dut4 reset donevalid", 64'(dv4), 64'(0));
        check("dut4 reset busy", 64'(busy4), 64'(0));
        check("dut4 reset sout", 64'(s4), 64'(0));
        check("dut4 reset co", 64'(co4), 64'(0));
        check("dut1 reset startready", 64'(sr1), 64'(1));
        check("dut1 reset sout", 64'(s1), 64'(0));

        foreach (vecs[i]) op4(vecs[i]);

        // Result held in DONE while the consumer stalls; starts must be refused throughout.
        v = '{32'h12345678, 32'h0F0F0F0F, 1'b1, 1'b0, 32'h21436588, 1'b0};
        start4(v);
        wait_done4();
        for (int k = 0; k < 5; k++) begin
            sv4 = 1'b1;
            a4  = $urandom; b4 = $urandom; ci4 = 1'b1;
            @(posedge clk); #1;
            check("hold donevalid", 64'(dv4), 64'(1));
            check("hold startready", 64'(sr4), 64'(0));
            check("hold sout", 64'(s4), 64'(32'h21436588));
            check("hold co", 64'(co4), 64'(0));
        end
        dr4 = 1'b1;
        @(posedge clk); #1;
        dr4 = 1'b0; sv4 = 1'b0;
        check("no done-to-run shortcut busy", 64'(busy4), 64'(0));
        check("no done-to-run shortcut ready", 64'(sr4), 64'(1));

        // Reset two cycles into RUN discards the operation.
        v = '{32'h11223344, 32'h01010101, 1'b0, 1'b0, 32'h12233445, 1'b0};
        a4 = v.a; b4 = v.b; ci4 = v.ci; sv4 = 1'b1;
        @(posedge clk); #1;
        sv4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid-run busy", 64'(busy4), 64'(1));
        rst4 = 1'b1;
        @(posedge clk); #1;
        rst4 = 1'b0;
        check("abort startready", 64'(sr4), 64'(1));
        check("abort donevalid", 64'(dv4), 64'(0));
        check("abort busy", 64'(busy4), 64'(0));
        check("abort sout", 64'(s4), 64'(0));
        check("abort co", 64'(co4), 64'(0));
        op4(vecs[2]);

        // Streaming, NBYTES=4: one accept every 6 cycles.
        sv4 = 1'b1; dr4 = 1'b1; last_acc = -1; nacc = 0;
        for (int c = 0; c < 60; c++) begin
            if (sr4) begin
                rs = 1'b0;
                a4 = $urandom; b4 = $urandom; ci4 = 1'($urandom_range(0, 1));
`ifdef SUB_EN
                rs = 1'($urandom_range(0, 1));
                sub4 = rs;
`endif
                exp4.push_back(model4(a4, b4, ci4, rs));
                if (last_acc >= 0) check("dut4 accept interval", 64'(c - last_acc), 64'(6));
                last_acc = c;
                nacc++;
            end
            @(posedge clk); #1;
        end
        sv4 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        dr4 = 1'b0;
        check("dut4 stream accepts", 64'(nacc), 64'(10));
        check("dut4 scoreboard drained", 64'(exp4.size()), 64'(0));

        // Streaming, NBYTES=1: one accept every 3 cycles.
        sv1 = 1'b1; dr1 = 1'b1; last_acc = -1; nacc = 0;
        for (int c = 0; c < 60; c++) begin
            if (sr1) begin
                rs = 1'b0;
                a1 = 8'($urandom); b1 = 8'($urandom); ci1 = 1'($urandom_range(0, 1));
`ifdef SUB_EN
                rs = 1'($urandom_range(0, 1));
                sub1 = rs;
`endif
                exp1.push_back(model1(a1, b1, ci1, rs));
                if (last_acc >= 0) check("dut1 accept interval", 64'(c - last_acc), 64'(3));
                last_acc = c;
                nacc++;
            end
            @(posedge clk); #1;
        end
        sv1 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        dr1 = 1'b0;
        check("dut1 stream accepts", 64'(nacc), 64'(20));
        check("dut1 scoreboard drained", 64'(exp1.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
